// File: rtl/opb_slave_if_pkg.sv
// opb_slave_if_pkg: FSM state encoding and default address window shared with the decoder map
package opb_slave_if_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    ACK     = 3'd3,
    RECOVER = 3'd4
  } state_t;
  localparam logic [31:0] BASEADDR_DEF = 32'h8000_0000;
  localparam logic [31:0] HIGHADDR_DEF = 32'h800F_FFFF;
endpackage

// File: rtl/opb_slave_if.sv
// opb_slave_if: qualifies OPB transfers in the peripheral window and turns them into registered decoder strobes
module opb_slave_if
  import opb_slave_if_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = BASEADDR_DEF,
  parameter logic [31:0] C_HIGHADDR = HIGHADDR_DEF,
  parameter int unsigned RD_WAIT    = 1
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        OPB_SELECT,
  input  logic        OPB_RNW,
  input  logic [31:0] OPB_ABUS,
  input  logic [3:0]  OPB_BE,
  input  logic [31:0] OPB_DBUS,
  output logic [31:0] SL_DBUS,
  output logic        SL_XFERACK,
  output logic        SL_ERRACK,
  output logic        SL_TOUTSUP,
  output logic        DEC_RE,
  output logic        DEC_WE,
  output logic [31:0] DEC_ADDR,
  output logic [31:0] DEC_DI,
  input  logic [31:0] DEC_DO
);
  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt;
  logic        r_err, w_err, w_hit;
  logic [31:0] r_addr, r_di, r_dbus;
  logic        r_xack, r_erra, r_tout, r_re, r_we;
  assign w_hit = OPB_SELECT && OPB_ABUS >= C_BASEADDR && OPB_ABUS <= C_HIGHADDR;
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    w_err  = r_err;
    case (r_state)
      IDLE: if (w_hit) begin
        w_err  = OPB_BE != 4'hF;
        w_cnt  = 4'(RD_WAIT);
        w_next = w_err ? ACK : OPB_RNW ? RD : WR;
      end
      WR: w_next = OPB_SELECT ? ACK : IDLE;
      RD: begin
        w_next = !OPB_SELECT ? IDLE : r_cnt != 4'd0 ? RD : ACK;
        w_cnt  = (OPB_SELECT && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
      end
      ACK:     w_next = RECOVER;
      default: w_next = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so every strobe and ack leaves a flop
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_di    <= '0;
      r_dbus  <= '0;
      r_xack  <= 1'b0;
      r_erra  <= 1'b0;
      r_tout  <= 1'b0;
      r_re    <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_err   <= w_err;
      if (r_state == IDLE && w_hit) begin
        r_addr <= OPB_ABUS - C_BASEADDR;
        r_di   <= OPB_DBUS;
      end
      r_dbus <= (r_state == RD && w_next == ACK) ? DEC_DO : '0;
      r_xack <= w_next == ACK;
      r_erra <= w_next == ACK && w_err;
      r_tout <= w_next == RD;
      r_re   <= w_next == RD;
      r_we   <= w_next == WR;
    end
  end
  assign SL_DBUS    = r_dbus;
  assign SL_XFERACK = r_xack;
  assign SL_ERRACK  = r_erra;
  assign SL_TOUTSUP = r_tout;
  assign DEC_RE     = r_re;
  assign DEC_WE     = r_we;
  assign DEC_ADDR   = r_addr;
  assign DEC_DI     = r_di;
endmodule

// File: tb/tb_opb_slave_if.sv
// tb_opb_slave_if: directed sequence with ack/write scoreboards against two wait-state configurations
module tb_opb_slave_if;
  logic        clk = 1'b0, rst = 1'b1;
  logic        sel = 1'b0, rnw = 1'b0;
  logic [31:0] abus = '0, dbus = '0, dec_do = '0;
  logic [3:0]  be = 4'hF;
  logic [31:0] sl_dbus, dec_addr, dec_di, sl_dbus3, dec_addr3, dec_di3;
  logic        sl_xferack, sl_errack, sl_toutsup, dec_re, dec_we;
  logic        xack3, erra3, tout3, re3, we3;
  int          errors = 0, checks = 0, cyc = 0, t = 0;
  bit          we_h[512], re_h[512], ack_h[512], re3_h[512], ack3_h[512];
  bit          any;
  logic [32:0] q_ack[$];
  logic [63:0] q_wr[$];
  logic [32:0] e_ack;
  logic [63:0] e_wr;
  always #5 clk = ~clk;
  opb_slave_if #(.RD_WAIT(1)) u_dut (
    .OPB_CLK(clk), .OPB_RST(rst), .OPB_SELECT(sel), .OPB_RNW(rnw), .OPB_ABUS(abus),
    .OPB_BE(be), .OPB_DBUS(dbus), .SL_DBUS(sl_dbus), .SL_XFERACK(sl_xferack),
    .SL_ERRACK(sl_errack), .SL_TOUTSUP(sl_toutsup), .DEC_RE(dec_re), .DEC_WE(dec_we),
    .DEC_ADDR(dec_addr), .DEC_DI(dec_di), .DEC_DO(dec_do)
  );
  opb_slave_if #(.RD_WAIT(3)) u_dut3 (
    .OPB_CLK(clk), .OPB_RST(rst), .OPB_SELECT(sel), .OPB_RNW(rnw), .OPB_ABUS(abus),
    .OPB_BE(be), .OPB_DBUS(dbus), .SL_DBUS(sl_dbus3), .SL_XFERACK(xack3),
    .SL_ERRACK(erra3), .SL_TOUTSUP(tout3), .DEC_RE(re3), .DEC_WE(we3),
    .DEC_ADDR(dec_addr3), .DEC_DI(dec_di3), .DEC_DO(dec_do)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
    we_h[cyc] = dec_we;
    re_h[cyc] = dec_re;
    ack_h[cyc] = sl_xferack;
    re3_h[cyc] = re3;
    ack3_h[cyc] = xack3;
    chk("strobe exclusive", 64'(dec_re & dec_we), 64'(0));
    chk("toutsup follows re", 64'(sl_toutsup), 64'(dec_re));
    if (sl_xferack) begin
      chk("ack expected", 64'(q_ack.size() != 0), 64'(1));
      if (q_ack.size() != 0) begin
        e_ack = q_ack.pop_front();
        chk("ack err/dbus", 64'({sl_errack, sl_dbus}), 64'(e_ack));
      end
    end else chk("no-ack err/dbus zero", 64'({sl_errack, sl_dbus}), 64'(0));
    if (dec_we) begin
      chk("write expected", 64'(q_wr.size() != 0), 64'(1));
      if (q_wr.size() != 0) begin
        e_wr = q_wr.pop_front();
        chk("write addr/di", {dec_addr, dec_di}, e_wr);
      end
    end
  endtask
  task automatic all_zero(input string tag);
    chk({tag, " dbus"}, 64'(sl_dbus), 64'(0));
    chk({tag, " addr/di"}, {dec_addr, dec_di}, 64'(0));
    chk({tag, " ctl"}, 64'({sl_xferack, sl_errack, sl_toutsup, dec_re, dec_we}), 64'(0));
    chk({tag, " u3"}, 64'({|sl_dbus3, xack3, erra3, tout3, re3, we3, |dec_addr3, |dec_di3}), 64'(0));
  endtask
  initial begin
    step();
    step();
    all_zero("reset");
    rst = 1'b0;
    step();
    step();
    // single write
    t = cyc;
    sel = 1'b1; rnw = 1'b0; abus = 32'h8006_0000; be = 4'hF; dbus = 32'h0000_00A5;
    q_wr.push_back({32'h0006_0000, 32'h0000_00A5});
    q_ack.push_back({1'b0, 32'h0});
    step();
    step();
    sel = 1'b0;
    step();
    step();
    chk("wr we +1", 64'(we_h[t+1]), 64'(1));
    chk("wr we +2", 64'(we_h[t+2]), 64'(0));
    chk("wr ack +1/+2/+3", 64'({ack_h[t+1], ack_h[t+2], ack_h[t+3]}), 64'(3'b010));
    // read with one wait state
    t = cyc;
    sel = 1'b1; rnw = 1'b1; abus = 32'h8003_0004; dec_do = 32'h1234_5678;
    q_ack.push_back({1'b0, 32'h1234_5678});
    step();
    chk("rd addr", 64'(dec_addr), 64'(32'h0003_0004));
    step();
    step();
    sel = 1'b0;
    step();
    step();
    step();
    chk("rd re +1..+3", 64'({re_h[t+1], re_h[t+2], re_h[t+3]}), 64'(3'b110));
    chk("rd ack +2/+3/+4", 64'({ack_h[t+2], ack_h[t+3], ack_h[t+4]}), 64'(3'b010));
    // partial byte enables
    t = cyc;
    sel = 1'b1; rnw = 1'b0; abus = 32'h8000_0010; be = 4'h3; dbus = 32'h0000_0077;
    q_ack.push_back({1'b1, 32'h0});
    step();
    sel = 1'b0; be = 4'hF;
    step();
    step();
    step();
    chk("be err ack +1", 64'(ack_h[t+1]), 64'(1));
    chk("be err no strobe", 64'({we_h[t+1], we_h[t+2], re_h[t+1]}), 64'(0));
    // outside the window
    t = cyc;
    sel = 1'b1; rnw = 1'b1; abus = 32'h8010_0000;
    repeat (20) step();
    sel = 1'b0;
    step();
    any = 1'b0;
    for (int i = 1; i <= 20; i++) any |= re_h[t+i] | we_h[t+i] | ack_h[t+i] | re3_h[t+i] | ack3_h[t+i];
    chk("outside quiet", 64'(any), 64'(0));
    // abort a read by dropping select
    t = cyc;
    sel = 1'b1; rnw = 1'b1; abus = 32'h8000_0100; dec_do = 32'hDEAD_BEEF;
    step();
    step();
    sel = 1'b0;
    repeat (6) step();
    chk("abort u3 re +1..+3", 64'({re3_h[t+1], re3_h[t+2], re3_h[t+3]}), 64'(3'b110));
    chk("abort re +3", 64'(re_h[t+3]), 64'(0));
    any = 1'b0;
    for (int i = 1; i <= 8; i++) any |= ack_h[t+i] | ack3_h[t+i];
    chk("abort no ack", 64'(any), 64'(0));
    // fresh read after abort
    t = cyc;
    sel = 1'b1; rnw = 1'b1; abus = 32'h8000_0200; dec_do = 32'hCAFE_0001;
    q_ack.push_back({1'b0, 32'hCAFE_0001});
    step();
    step();
    step();
    sel = 1'b0;
    step();
    step();
    step();
    chk("fresh rd ack +3", 64'(ack_h[t+3]), 64'(1));
    // select held through ack: recovery slot then a second transfer
    t = cyc;
    sel = 1'b1; rnw = 1'b0; abus = 32'h8000_0020; be = 4'hF; dbus = 32'h0000_0011;
    q_wr.push_back({32'h0000_0020, 32'h0000_0011});
    q_ack.push_back({1'b0, 32'h0});
    q_wr.push_back({32'h0000_0020, 32'h0000_0022});
    q_ack.push_back({1'b0, 32'h0});
    step();
    step();
    step();
    dbus = 32'h0000_0022;
    step();
    step();
    step();
    sel = 1'b0;
    step();
    step();
    step();
    chk("b2b we +1..+5", 64'({we_h[t+1], we_h[t+2], we_h[t+3], we_h[t+4], we_h[t+5]}), 64'(5'b10001));
    chk("b2b recover quiet", 64'({re_h[t+3], ack_h[t+3], re_h[t+4], ack_h[t+4]}), 64'(0));
    chk("b2b ack +2/+6", 64'({ack_h[t+2], ack_h[t+6]}), 64'(2'b11));
    // asynchronous reset in the middle of a read
    t = cyc;
    sel = 1'b1; rnw = 1'b1; abus = 32'h8000_0300; dec_do = 32'h5555_5555;
    step();
    chk("pre-rst re", 64'(dec_re), 64'(1));
    #2 rst = 1'b1;
    #1 all_zero("async rst");
    sel = 1'b0;
    step();
    rst = 1'b0;
    repeat (4) step();
    any = 1'b0;
    for (int i = 1; i <= 5; i++) any |= ack_h[t+i] | ack3_h[t+i];
    chk("rst no ack", 64'(any), 64'(0));
    chk("ack queue drained", 64'(q_ack.size()), 64'(0));
    chk("write queue drained", 64'(q_wr.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
